// File: rtl/change_event_if.sv
// change_event_if: change-event arbiter bus; the arbiter uses the slave modport, the consumer/stimulus side uses the master modport.
interface change_event_if #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
);
  logic           enable;
  logic [N-1:0]   sig_in;
  logic           evt_valid;
  logic           evt_ready;
  logic [IDW-1:0] evt_id;
  logic           evt_level;
  logic [N-1:0]   overflow;
  logic           ovf_clr;
  logic [15:0]    evt_count;
  modport slave (
    input  enable, sig_in, evt_ready, ovf_clr,
    output evt_valid, evt_id, evt_level, overflow, evt_count
  );
  modport master (
    output enable, sig_in, evt_ready, ovf_clr,
    input  evt_valid, evt_id, evt_level, overflow, evt_count
  );
endinterface

// File: rtl/change_event_arbiter.sv
// change_event_arbiter: detects per-channel value changes and offers them one at a time, round-robin, over a valid/ready channel.
module change_event_arbiter #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input logic           clk,
  input logic           rst_n,
  change_event_if.slave bus
);
  typedef enum logic {IDLE, OFFER} state_t;
  state_t         state, state_n;
  logic [N-1:0]   prev, pending, lvl, overflow, change, gnt_mask, ovf_set;
  logic           primed, grant, hs, evt_level;
  logic [IDW-1:0] rr_ptr, gnt_id, evt_id;
  logic [IDW:0]   idx;
  logic [15:0]    evt_count;
  assign change   = (primed && bus.enable) ? (bus.sig_in ^ prev) : '0;
  assign grant    = (state == IDLE) && (|pending);
  assign hs       = (state == OFFER) && bus.evt_ready;
  assign gnt_mask = grant ? (N'(1) << gnt_id) : '0;
  assign ovf_set  = change & pending & ~gnt_mask;
  // Scan downward so the closest pending channel at or after rr_ptr wins last.
  always_comb begin
    gnt_id = '0;
    idx    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(N)) idx = idx - (IDW+1)'(N);
      if (pending[idx[IDW-1:0]]) gnt_id = idx[IDW-1:0];
    end
  end
  always_comb begin
    state_n = grant ? OFFER : (hs ? IDLE : state);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end
  // A change on the grant edge of its own channel re-arms pending with the new level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev      <= '0;
      primed    <= 1'b0;
      pending   <= '0;
      lvl       <= '0;
      overflow  <= '0;
      evt_id    <= '0;
      evt_level <= 1'b0;
      rr_ptr    <= '0;
      evt_count <= '0;
    end else begin
      prev     <= bus.sig_in;
      primed   <= 1'b1;
      pending  <= (pending & ~gnt_mask) | change;
      lvl      <= (lvl & ~change) | (bus.sig_in & change);
      overflow <= (bus.ovf_clr ? '0 : overflow) | ovf_set;
      if (grant) begin
        evt_id    <= gnt_id;
        evt_level <= lvl[gnt_id];
      end
      if (hs) begin
        rr_ptr    <= (evt_id == IDW'(N - 1)) ? '0 : evt_id + 1'b1;
        evt_count <= evt_count + {15'd0, evt_count != 16'hFFFF};
      end
    end
  end
  assign bus.evt_valid = (state == OFFER);
  assign bus.evt_id    = evt_id;
  assign bus.evt_level = evt_level;
  assign bus.overflow  = overflow;
  assign bus.evt_count = evt_count;
endmodule

// File: tb/tb_change_event_arbiter.sv
// tb_change_event_arbiter: directed vectors with hand-computed expectations for the N=4 change-event arbiter.
module tb_change_event_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  change_event_if #(.N(4)) bus ();
  change_event_arbiter #(.N(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic expect_evt(input string tag, input logic [1:0] id, input logic lvl);
    check({tag, "_valid"}, 32'(bus.evt_valid), 32'd1);
    check({tag, "_id"}, 32'(bus.evt_id), 32'(id));
    check({tag, "_level"}, 32'(bus.evt_level), 32'(lvl));
  endtask
  task automatic reset_cycle(input logic [3:0] s);
    rst_n = 1'b0;
    #1;
    tick();
    bus.sig_in = s;
    rst_n = 1'b1;
    tick();
  endtask
  initial begin
    bus.enable = 1'b1;
    bus.sig_in = 4'b0000;
    bus.evt_ready = 1'b0;
    bus.ovf_clr = 1'b0;
    #2;
    check("rst_valid", 32'(bus.evt_valid), 32'd0);
    check("rst_count", 32'(bus.evt_count), 32'd0);
    check("rst_ovf", 32'(bus.overflow), 32'd0);
    check("rst_id", 32'(bus.evt_id), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    // single change on channel 2
    bus.sig_in = 4'b0100;
    tick();
    check("single_e0_valid", 32'(bus.evt_valid), 32'd0);
    tick();
    expect_evt("single", 2'd2, 1'b1);
    bus.evt_ready = 1'b1;
    tick();
    check("single_done", 32'(bus.evt_valid), 32'd0);
    check("single_count", 32'(bus.evt_count), 32'd1);
    // round-robin bursts from a fresh pointer
    bus.evt_ready = 1'b0;
    reset_cycle(4'b0000);
    bus.evt_ready = 1'b1;
    bus.sig_in = 4'b1111;
    tick();
    check("rr1_e0_valid", 32'(bus.evt_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_evt("rr1", 2'(i), 1'b1);
      tick();
      check("rr1_gap", 32'(bus.evt_valid), 32'd0);
    end
    check("rr1_count", 32'(bus.evt_count), 32'd4);
    bus.sig_in = 4'b0000;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_evt("rr2", 2'(i), 1'b0);
      tick();
      check("rr2_gap", 32'(bus.evt_valid), 32'd0);
    end
    check("rr2_count", 32'(bus.evt_count), 32'd8);
    // backpressure: channel 1 toggles 0->1->0->1 while its first event is held
    bus.evt_ready = 1'b0;
    bus.sig_in = 4'b0010;
    tick();
    bus.sig_in = 4'b0000;
    tick();
    expect_evt("bp_first", 2'd1, 1'b1);
    bus.sig_in = 4'b0010;
    tick();
    for (int i = 0; i < 3; i++) begin
      expect_evt("bp_hold", 2'd1, 1'b1);
      check("bp_ovf", 32'(bus.overflow), 32'h2);
      tick();
    end
    bus.evt_ready = 1'b1;
    tick();
    check("bp_hs", 32'(bus.evt_valid), 32'd0);
    check("bp_count", 32'(bus.evt_count), 32'd9);
    tick();
    expect_evt("bp_last", 2'd1, 1'b1);
    tick();
    check("bp_count2", 32'(bus.evt_count), 32'd10);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    check("ovf_clr", 32'(bus.overflow), 32'd0);
    // same-edge grant and change on channel 0 (rr_ptr is 2)
    bus.sig_in = 4'b0011;
    tick();
    bus.sig_in = 4'b0010;
    tick();
    expect_evt("same_a", 2'd0, 1'b1);
    tick();
    check("same_gap", 32'(bus.evt_valid), 32'd0);
    tick();
    expect_evt("same_b", 2'd0, 1'b0);
    tick();
    check("same_done", 32'(bus.evt_valid), 32'd0);
    check("same_ovf", 32'(bus.overflow), 32'd0);
    check("same_count", 32'(bus.evt_count), 32'd12);
    // enable gate on channel 2
    bus.enable = 1'b0;
    bus.sig_in = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("dis_quiet", 32'(bus.evt_valid), 32'd0);
    end
    bus.enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reen_quiet", 32'(bus.evt_valid), 32'd0);
    end
    bus.sig_in = 4'b0010;
    tick();
    check("en_e0", 32'(bus.evt_valid), 32'd0);
    tick();
    expect_evt("en_evt", 2'd2, 1'b0);
    tick();
    check("en_count", 32'(bus.evt_count), 32'd13);
    // reset while an event is in flight
    bus.evt_ready = 1'b0;
    bus.sig_in = 4'b0000;
    tick();
    tick();
    expect_evt("mid_offer", 2'd1, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.evt_valid), 32'd0);
    check("mid_rst_count", 32'(bus.evt_count), 32'd0);
    bus.sig_in = 4'b1111;
    tick();
    rst_n = 1'b1;
    bus.evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_quiet", 32'(bus.evt_valid), 32'd0);
    end
    check("post_rst_count", 32'(bus.evt_count), 32'd0);
    check("post_rst_ovf", 32'(bus.overflow), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
